// File: rtl/fifo_disp_pkg.sv
// Shared definitions for the button-driven FIFO / 7-segment display slice.
// Holds the occupancy width that the display stage expects, the default word
// width, the debounce counter width, and the debouncer state encoding.
package fifo_disp_pkg;

  // Largest queue that still fits the 4-bit display input.
  localparam int DEPTH_MAX      = 15;
  localparam int CNT_W          = 4;
  localparam int DATA_W_DEFAULT = 4;
  localparam int DB_W           = 20;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_WAIT_PRESS,
    KEY_HELD,
    KEY_WAIT_RELEASE
  } key_state_t;

  // A single-entry queue still needs a one-bit pointer register.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Conditions one raw push button into a single-cycle pulse.
// Chain: 2-FF synchronizer -> stability counter FSM -> registered one-shot.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   key    in  1  raw button level, active-high, asynchronous to clk
//   pulse  out 1  one-cycle pulse when a press has been stable for DB_CYCLES
module key_pulse
  import fifo_disp_pkg::*;
#(
  parameter logic [DB_W-1:0] DB_CYCLES = 20'd500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  logic            key_meta;
  logic            key_sync;
  key_state_t      state;
  key_state_t      state_next;
  logic [DB_W-1:0] cnt;
  logic [DB_W-1:0] cnt_next;
  logic            pulse_next;

  // Bring the asynchronous button into the clock domain before any decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Debounce state, stability counter and the registered one-shot output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= KEY_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
    end
  end

  // Any change of the synchronized level falls back to the last accepted
  // state, which restarts the stability count on the next change. Only the
  // transition into KEY_HELD fires the pulse, so holding a key gives one pulse
  // and a release must itself be stable before the key re-arms.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    case (state)
      KEY_IDLE: begin
        if (key_sync) begin
          state_next = KEY_WAIT_PRESS;
          cnt_next   = DB_W'(1);
        end
      end
      KEY_WAIT_PRESS: begin
        if (!key_sync) begin
          state_next = KEY_IDLE;
        end else if (cnt >= DB_CYCLES) begin
          state_next = KEY_HELD;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + DB_W'(1);
        end
      end
      KEY_HELD: begin
        if (!key_sync) begin
          state_next = KEY_WAIT_RELEASE;
          cnt_next   = DB_W'(1);
        end
      end
      KEY_WAIT_RELEASE: begin
        if (key_sync) begin
          state_next = KEY_HELD;
        end else if (cnt >= DB_CYCLES) begin
          state_next = KEY_IDLE;
        end else begin
          cnt_next = cnt + DB_W'(1);
        end
      end
      default: state_next = KEY_IDLE;
    endcase
  end

endmodule

// File: rtl/fifo_occupancy_ctrl.sv
// Button-driven synchronous FIFO feeding the 7-segment display stage.
// Debounced push/pop keys move DATA_W-bit switch words through a DEPTH-entry
// queue; occupancy and flags are exported for the display.
// Ports:
//   clk        in  1       system clock
//   rst_n      in  1       asynchronous active-low reset
//   push_key   in  1       raw push button, active-high
//   pop_key    in  1       raw pop button, active-high
//   data_in    in  DATA_W  switch value stored on an accepted push
//   data_out   out DATA_W  registered head-of-queue word, 0 when empty
//   count      out 4       entries held, 0..DEPTH
//   is_full    out 1       count == DEPTH
//   is_empty   out 1       count == 0
//   push_drop  out 1       one-cycle strobe, push rejected because full
//   pop_drop   out 1       one-cycle strobe, pop rejected because empty
module fifo_occupancy_ctrl
  import fifo_disp_pkg::*;
#(
  parameter int               DEPTH     = DEPTH_MAX,
  parameter int               DATA_W    = DATA_W_DEFAULT,
  parameter logic [DB_W-1:0]  DB_CYCLES = 20'd500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_key,
  input  logic              pop_key,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              is_full,
  output logic              is_empty,
  output logic              push_drop,
  output logic              pop_drop
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [1:0]        rst_pipe;
  logic              rst_int_n;
  logic              push_p;
  logic              pop_p;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  wr_next;
  logic [PTR_W-1:0]  rd_next;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] head_next;
  logic              push_drop_next;
  logic              pop_drop_next;

  // Pointers wrap at DEPTH rather than at a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Reset asserts asynchronously but releases only on a clock edge, so no
  // flop sees reset removal close to its sampling instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  key_pulse #(.DB_CYCLES(DB_CYCLES)) u_push_key (
    .clk   (clk),
    .rst_n (rst_int_n),
    .key   (push_key),
    .pulse (push_p)
  );

  key_pulse #(.DB_CYCLES(DB_CYCLES)) u_pop_key (
    .clk   (clk),
    .rst_n (rst_int_n),
    .key   (pop_key),
    .pulse (pop_p)
  );

  // Decide which operations happen this cycle. A simultaneous pop frees the
  // slot a push needs when full, and an empty queue turns a simultaneous pair
  // into a plain push. The head word is forwarded from data_in when the slot
  // being written is the one that becomes the new head.
  always_comb begin
    do_push        = push_p & (pop_p | ~is_full);
    do_pop         = pop_p & ~is_empty;
    push_drop_next = push_p & ~pop_p & is_full;
    pop_drop_next  = pop_p & ~push_p & is_empty;

    wr_next = do_push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_next = do_pop  ? ptr_inc(rd_ptr) : rd_ptr;

    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end

    head_next = '0;
    if (count_next != '0) begin
      if (do_push && (wr_ptr == rd_next)) begin
        head_next = data_in;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  // Storage is deliberately not reset; stale words are never visible because
  // data_out is forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, flags and outputs all update on the same edge so
  // the display never sees them disagree.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      is_full   <= 1'b0;
      is_empty  <= 1'b1;
      data_out  <= '0;
      push_drop <= 1'b0;
      pop_drop  <= 1'b0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      count     <= count_next;
      is_full   <= (count_next == CNT_W'(DEPTH));
      is_empty  <= (count_next == '0);
      data_out  <= head_next;
      push_drop <= push_drop_next;
      pop_drop  <= pop_drop_next;
    end
  end

endmodule

// File: tb/tb_fifo_occupancy_ctrl.sv
// Scoreboard bench for fifo_occupancy_ctrl with a short debounce window.
// A queue-based reference model predicts every key operation; expectations
// carry the cycle at which the registered update must be visible, and a
// monitor process compares the outputs when that cycle arrives.
module tb_fifo_occupancy_ctrl;

  localparam int DEPTH = 15;
  localparam int DW    = 4;
  localparam int DB    = 4;

  typedef struct {
    int          due;
    logic [3:0]  cnt;
    logic [DW-1:0] dout;
    logic        full;
    logic        empty;
    logic        pdrop;
    logic        qdrop;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          push_key = 1'b0;
  logic          pop_key = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [3:0]    count;
  logic          is_full;
  logic          is_empty;
  logic          push_drop;
  logic          pop_drop;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];

  fifo_occupancy_ctrl #(
    .DEPTH     (DEPTH),
    .DATA_W    (DW),
    .DB_CYCLES (20'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_key  (push_key),
    .pop_key   (pop_key),
    .data_in   (data_in),
    .data_out  (data_out),
    .count     (count),
    .is_full   (is_full),
    .is_empty  (is_empty),
    .push_drop (push_drop),
    .pop_drop  (pop_drop)
  );

  // 10-unit clock and a free-running cycle index used to time expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: apply one operation to the queue and push the expected
  // outputs for the update cycle and for the cycle after it (strobes gone).
  task automatic modelOp(input bit p, input bit q, input logic [DW-1:0] d, input int due);
    exp_t e;
    bit   pd;
    bit   qd;
    pd = 1'b0;
    qd = 1'b0;
    if (p && q) begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      model_q.push_back(d);
    end else if (p) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else pd = 1'b1;
    end else if (q) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      else qd = 1'b1;
    end
    e.due   = due;
    e.cnt   = 4'(model_q.size());
    e.dout  = (model_q.size() > 0) ? model_q[0] : '0;
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    e.pdrop = pd;
    e.qdrop = qd;
    exp_q.push_back(e);
    e.due   = due + 1;
    e.pdrop = 1'b0;
    e.qdrop = 1'b0;
    exp_q.push_back(e);
  endtask

  // Press the selected keys (optionally with contact bounce on push), hold
  // past the update, then release and wait out the release debounce.
  task automatic applyStimulus(input bit p, input bit q, input logic [DW-1:0] d, input bit bounce);
    int t0;
    @(posedge clk); #1;
    data_in = d;
    if (bounce) begin
      push_key = 1'b1; @(posedge clk); #1;
      push_key = 1'b0; @(posedge clk); #1;
      push_key = 1'b1; repeat (2) @(posedge clk); #1;
      push_key = 1'b0; @(posedge clk); #1;
    end
    push_key = p;
    pop_key  = q;
    t0 = cyc;
    modelOp(p, q, d, t0 + DB + 4);
    repeat (DB + 8) @(posedge clk); #1;
    push_key = 1'b0;
    pop_key  = 1'b0;
    repeat (DB + 6) @(posedge clk);
  endtask

  // Monitor: compare when an expectation falls due, otherwise the drop
  // strobes must stay low.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checkOutput("missed_expectation", 32'(cyc), 32'(e.due));
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checkOutput("count",     count,     e.cnt);
      checkOutput("data_out",  data_out,  e.dout);
      checkOutput("is_full",   is_full,   e.full);
      checkOutput("is_empty",  is_empty,  e.empty);
      checkOutput("push_drop", push_drop, e.pdrop);
      checkOutput("pop_drop",  pop_drop,  e.qdrop);
    end else begin
      checkOutput("idle_push_drop", push_drop, 0);
      checkOutput("idle_pop_drop",  pop_drop,  0);
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_count"},     count,     0);
    checkOutput({tag, "_data_out"},  data_out,  0);
    checkOutput({tag, "_is_full"},   is_full,   0);
    checkOutput({tag, "_is_empty"},  is_empty,  1);
    checkOutput({tag, "_push_drop"}, push_drop, 0);
    checkOutput({tag, "_pop_drop"},  pop_drop,  0);
  endtask

  initial begin
    int  lat;
    bit  found;
    int  t_rel;
    int  r;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    $display("[TB] bounced push, then fill to full");
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b1);
    for (int v = 2; v <= 15; v++) applyStimulus(1'b1, 1'b0, DW'(v), 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

    $display("[TB] drain and pop past empty");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);

    $display("[TB] pointer wrap");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0);
    @(negedge clk);
    checkOutput("wrap_count", count, 12);

    $display("[TB] simultaneous push and pop at 0, 7, 15");
    while (model_q.size() > 0) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, DW'($urandom), 1'b0);
    while (model_q.size() < 7) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, DW'($urandom), 1'b0);
    while (model_q.size() < 15) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, DW'($urandom), 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      applyStimulus(r != 1, r != 0, DW'($urandom), 1'b0);
    end

    $display("[TB] reset while a push key is held");
    while (model_q.size() < 9) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0);
    while (model_q.size() > 9) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    @(posedge clk); #1;
    data_in  = 4'hA;
    push_key = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checkResetValues("async_reset");
    @(negedge clk);
    checkResetValues("held_reset");
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    model_q.delete();
    t_rel = cyc;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (count == 4'd1) begin
        found = 1'b1;
        lat   = cyc - t_rel;
      end
    end
    checkOutput("rst_push_seen", found, 1);
    checks++;
    if (lat < DB + 4 || lat > DB + 8) begin
      errors++;
      $display("[TB] FAIL rst_push_latency: got %0d cycles expected %0d..%0d", lat, DB + 4, DB + 8);
    end
    checkOutput("rst_push_data", data_out, 4'hA);
    repeat (10) @(negedge clk);
    checkOutput("rst_single_push", count, 1);
    model_q.push_back(4'hA);
    @(posedge clk); #1;
    push_key = 1'b0;
    repeat (DB + 8) @(posedge clk);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);

    repeat (4) @(posedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
